// File: rtl/lsoc1000_stage_de_pipe.sv
// Decode-stage pipeline register between DE1 and DE2.
// Each captured group is truncated after its first excepting lane and compacted
// toward lane 0. An optional skid entry lets in_ready come straight from a flop.
module lsoc1000_stage_de_pipe #(
    parameter int NPORT  = 3,
    parameter int GRLEN  = 32,
    parameter int HINT_W = 4,
    parameter int SKID   = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        flush,
    input  logic [NPORT-1:0]            in_valid,
    input  logic [NPORT*GRLEN-1:0]      in_pc,
    input  logic [NPORT*32-1:0]         in_inst,
    input  logic [NPORT*(GRLEN-2)-1:0]  in_br_target,
    input  logic [NPORT-1:0]            in_br_taken,
    input  logic [NPORT-1:0]            in_exception,
    input  logic [NPORT*6-1:0]          in_exccode,
    input  logic [NPORT*HINT_W-1:0]     in_hint,
    output logic                        in_ready,
    input  logic                        allow_in,
    output logic [NPORT-1:0]            out_valid,
    output logic [NPORT*GRLEN-1:0]      out_pc,
    output logic [NPORT*32-1:0]         out_inst,
    output logic [NPORT*(GRLEN-2)-1:0]  out_br_target,
    output logic [NPORT-1:0]            out_br_taken,
    output logic [NPORT-1:0]            out_exception,
    output logic [NPORT*6-1:0]          out_exccode,
    output logic [NPORT*HINT_W-1:0]     out_hint
);

    localparam int TW = GRLEN - 2;
    localparam int LW = GRLEN + 32 + TW + 1 + 1 + 6 + HINT_W;

    logic [NPORT-1:0]    main_vld_q, main_vld_d;
    logic [NPORT-1:0]    skid_vld_q, skid_vld_d;
    logic [NPORT*LW-1:0] main_data_q, main_data_d;
    logic [NPORT*LW-1:0] skid_data_q, skid_data_d;
    logic [NPORT-1:0]    cap_vld;
    logic [NPORT*LW-1:0] cap_data;
    logic                main_full;
    logic                skid_full;
    logic                accept;
    logic                xfer;

    assign main_full = |main_vld_q;
    assign skid_full = |skid_vld_q;

    // With a skid entry in_ready depends only on flops; without one it must
    // look at allow_in to sustain one group per cycle.
    assign in_ready = (SKID != 0) ? !skid_full : (!main_full || allow_in);
    assign accept   = (|in_valid) && in_ready;
    assign xfer     = main_full && allow_in;

    // Truncate after the lowest excepting valid lane, then pack survivors from lane 0.
    always_comb begin
        int   k;
        logic stop;
        cap_vld  = '0;
        cap_data = '0;
        k        = 0;
        stop     = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            if (in_valid[i] && !stop) begin
                for (int j = 0; j < NPORT; j++) begin
                    if (j == k) begin
                        cap_vld[j]            = 1'b1;
                        cap_data[j*LW +: LW]  = {in_pc[i*GRLEN +: GRLEN],
                                                 in_inst[i*32 +: 32],
                                                 in_br_target[i*TW +: TW],
                                                 in_br_taken[i],
                                                 in_exception[i],
                                                 in_exccode[i*6 +: 6],
                                                 in_hint[i*HINT_W +: HINT_W]};
                    end
                end
                k = k + 1;
                if (in_exception[i]) begin
                    stop = 1'b1;
                end
            end
        end
    end

    // Entry next-state. The skid branch is unreachable when SKID=0 because
    // in_ready is low whenever MAIN is held.
    always_comb begin
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            main_vld_d  = '0;
            main_data_d = '0;
            skid_vld_d  = '0;
            skid_data_d = '0;
        end else if (!main_full || xfer) begin
            if (skid_full) begin
                main_vld_d  = skid_vld_q;
                main_data_d = skid_data_q;
                skid_vld_d  = '0;
                skid_data_d = '0;
            end else if (accept) begin
                main_vld_d  = cap_vld;
                main_data_d = cap_data;
            end else begin
                main_vld_d  = '0;
                main_data_d = '0;
            end
        end else if (accept) begin
            skid_vld_d  = cap_vld;
            skid_data_d = cap_data;
        end
    end

    // Entry registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            main_vld_q  <= '0;
            main_data_q <= '0;
            skid_vld_q  <= '0;
            skid_data_q <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_data_q <= main_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign out_valid = main_vld_q;

    for (genvar g = 0; g < NPORT; g++) begin : g_unpack
        assign {out_pc[g*GRLEN +: GRLEN],
                out_inst[g*32 +: 32],
                out_br_target[g*TW +: TW],
                out_br_taken[g],
                out_exception[g],
                out_exccode[g*6 +: 6],
                out_hint[g*HINT_W +: HINT_W]} = main_data_q[g*LW +: LW];
    end

endmodule

// File: tb/tb_lsoc1000_stage_de_pipe.sv
// Scoreboard bench: two instances (SKID=1 and SKID=0) share payload buses and flush.
module tb_lsoc1000_stage_de_pipe;

    localparam int N  = 3;
    localparam int G  = 32;
    localparam int H  = 4;
    localparam int T  = G - 2;
    localparam int OW = N * (1 + G + 32 + T + 1 + 1 + 6 + H);

    int n_vec = 0;
    int n_err = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           resetn, flush;
    logic [N-1:0]   iv1, iv0, itk, iexc;
    logic [N*G-1:0] ipc;
    logic [N*32-1:0] iinst;
    logic [N*T-1:0] itgt;
    logic [N*6-1:0] icode;
    logic [N*H-1:0] ihint;
    logic           allow1, allow0, rdy1, rdy0;

    logic [N-1:0]   ov1, otk1, oexc1, ov0, otk0, oexc0;
    logic [N*G-1:0] opc1, opc0;
    logic [N*32-1:0] oinst1, oinst0;
    logic [N*T-1:0] otgt1, otgt0;
    logic [N*6-1:0] ocode1, ocode0;
    logic [N*H-1:0] ohint1, ohint0;
    logic [OW-1:0]  out1, out0;

    assign out1 = {ov1, opc1, oinst1, otgt1, otk1, oexc1, ocode1, ohint1};
    assign out0 = {ov0, opc0, oinst0, otgt0, otk0, oexc0, ocode0, ohint0};

    lsoc1000_stage_de_pipe #(.NPORT(N), .GRLEN(G), .HINT_W(H), .SKID(1)) u1 (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(iv1),
        .in_pc(ipc), .in_inst(iinst), .in_br_target(itgt), .in_br_taken(itk),
        .in_exception(iexc), .in_exccode(icode), .in_hint(ihint),
        .in_ready(rdy1), .allow_in(allow1), .out_valid(ov1),
        .out_pc(opc1), .out_inst(oinst1), .out_br_target(otgt1), .out_br_taken(otk1),
        .out_exception(oexc1), .out_exccode(ocode1), .out_hint(ohint1));

    lsoc1000_stage_de_pipe #(.NPORT(N), .GRLEN(G), .HINT_W(H), .SKID(0)) u0 (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(iv0),
        .in_pc(ipc), .in_inst(iinst), .in_br_target(itgt), .in_br_taken(itk),
        .in_exception(iexc), .in_exccode(icode), .in_hint(ihint),
        .in_ready(rdy0), .allow_in(allow0), .out_valid(ov0),
        .out_pc(opc0), .out_inst(oinst0), .out_br_target(otgt0), .out_br_taken(otk0),
        .out_exception(oexc0), .out_exccode(ocode0), .out_hint(ohint0));

    // Reference: walk lanes upward, append each valid lane, stop after an exception.
    function automatic logic [OW-1:0] model(input logic [N-1:0] iv);
        logic [N-1:0]   v, tk, ex;
        logic [N*G-1:0] pc;
        logic [N*32-1:0] inst;
        logic [N*T-1:0] tgt;
        logic [N*6-1:0] code;
        logic [N*H-1:0] hint;
        int k;
        v = '0; tk = '0; ex = '0; pc = '0; inst = '0; tgt = '0; code = '0; hint = '0;
        k = 0;
        for (int i = 0; i < N; i++) begin
            if (iv[i]) begin
                v[k]              = 1'b1;
                pc[k*G +: G]      = ipc[i*G +: G];
                inst[k*32 +: 32]  = iinst[i*32 +: 32];
                tgt[k*T +: T]     = itgt[i*T +: T];
                tk[k]             = itk[i];
                ex[k]             = iexc[i];
                code[k*6 +: 6]    = icode[i*6 +: 6];
                hint[k*H +: H]    = ihint[i*H +: H];
                k++;
                if (iexc[i]) break;
            end
        end
        return {v, pc, inst, tgt, tk, ex, code, hint};
    endfunction

    task automatic chk(input string nm, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Scoreboard state: held = groups inside the DUT, updated only at posedge.
    logic [OW-1:0] q1[$], q0[$];
    int            held1 = 0, held0 = 0;
    logic          p_acc1 = 0, p_xfer1 = 0, p_fl1 = 0;
    logic          p_acc0 = 0, p_xfer0 = 0, p_fl0 = 0;
    logic [OW-1:0] p_grp1, p_grp0;

    // Stimulus recorders: decide at negedge what the coming edge does.
    always @(negedge clk) begin
        logic er;
        if (resetn) begin
            er = held1 < 2;
            chk("in_ready_skid1", OW'(rdy1), OW'(er));
            p_acc1  = (|iv1) && er && !flush;
            p_grp1  = model(iv1);
            p_xfer1 = (held1 > 0) && allow1 && !flush;
            p_fl1   = flush;
        end
    end

    always @(negedge clk) begin
        logic er;
        if (resetn) begin
            er = (held0 == 0) || allow0;
            chk("in_ready_skid0", OW'(rdy0), OW'(er));
            p_acc0  = (|iv0) && er && !flush;
            p_grp0  = model(iv0);
            p_xfer0 = (held0 > 0) && allow0 && !flush;
            p_fl0   = flush;
        end
    end

    // Commit expectations at the edge.
    always @(posedge clk) begin
        if (!resetn || p_fl1) begin
            q1.delete(); held1 = 0;
        end else begin
            if (p_xfer1) held1--;
            if (p_acc1) begin q1.push_back(p_grp1); held1++; end
        end
        if (!resetn || p_fl0) begin
            q0.delete(); held0 = 0;
        end else begin
            if (p_xfer0) held0--;
            if (p_acc0) begin q0.push_back(p_grp0); held0++; end
        end
        p_acc1 = 0; p_xfer1 = 0; p_fl1 = 0;
        p_acc0 = 0; p_xfer0 = 0; p_fl0 = 0;
    end

    // Output monitors.
    always @(negedge clk) begin
        if (resetn) begin
            chk("out_present_skid1", OW'(|ov1), OW'(held1 > 0));
            if (held1 > 0 && allow1 && !flush && q1.size() > 0)
                chk("group_skid1", out1, q1.pop_front());
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            chk("out_present_skid0", OW'(|ov0), OW'(held0 > 0));
            if (held0 > 0 && allow0 && !flush && q0.size() > 0)
                chk("group_skid0", out0, q0.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_in();
        for (int i = 0; i < N; i++) begin
            ipc[i*G +: G]     = G'($urandom);
            iinst[i*32 +: 32] = 32'($urandom);
            itgt[i*T +: T]    = T'($urandom);
            icode[i*6 +: 6]   = 6'($urandom);
            ihint[i*H +: H]   = H'($urandom);
        end
        itk  = N'($urandom);
        iexc = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
    endtask

    task automatic do_flush();
        iv1 = '0; iv0 = '0; flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        logic [5:0] c1;
        resetn = 1'b0; flush = 1'b0; iv1 = '0; iv0 = '0; allow1 = 1'b0; allow0 = 1'b0;
        ipc = '0; iinst = '0; itgt = '0; itk = '0; iexc = '0; icode = '0; ihint = '0;
        #2;
        chk("reset_out1", out1, '0);
        chk("reset_out0", out0, '0);
        chk("reset_rdy1", OW'(rdy1), OW'(1'b1));
        chk("reset_rdy0", OW'(rdy0), OW'(1'b1));
        @(posedge clk); #1;
        resetn = 1'b1;
        step();

        // Compaction.
        do_flush();
        rand_in(); iexc = '0; allow1 = 1'b0;
        ipc = {32'h0000_0108, 32'h0000_0104, 32'h0000_0100};
        iv1 = 3'b101;
        step();
        iv1 = '0;
        chk("t2_valid", OW'(ov1), OW'(3'b011));
        chk("t2_pc", OW'(opc1), OW'({32'h0, 32'h108, 32'h100}));
        allow1 = 1'b1; step();

        // Exception truncation.
        allow1 = 1'b0;
        rand_in(); iexc = 3'b010; icode[6 +: 6] = 6'h08;
        iv1 = 3'b111;
        step();
        iv1 = '0;
        c1 = ocode1[6 +: 6];
        chk("t3_valid", OW'(ov1), OW'(3'b011));
        chk("t3_exc", OW'(oexc1[1]), OW'(1'b1));
        chk("t3_code", OW'(c1), OW'(6'h08));
        allow1 = 1'b1; step();

        // Skid fill and drain.
        allow1 = 1'b0;
        rand_in(); iexc = '0; iv1 = 3'b011; step();
        rand_in(); iexc = '0; iv1 = 3'b111; step();
        iv1 = '0;
        chk("t4_rdy_low", OW'(rdy1), OW'(1'b0));
        allow1 = 1'b1;
        step();
        step();
        chk("t4_rdy_back", OW'(rdy1), OW'(1'b1));
        chk("t4_empty", OW'(ov1), OW'(0));

        // Flush with both entries full and a group offered.
        allow1 = 1'b0;
        rand_in(); iv1 = 3'b001; step();
        rand_in(); iv1 = 3'b110; step();
        rand_in(); iv1 = 3'b111; flush = 1'b1; step();
        flush = 1'b0; iv1 = '0;
        chk("t5_valid", OW'(ov1), OW'(0));
        chk("t5_rdy", OW'(rdy1), OW'(1'b1));
        allow1 = 1'b1;
        repeat (3) step();

        // Random traffic on the skid instance.
        for (int c = 0; c < 300; c++) begin
            rand_in();
            iv1    = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            allow1 = ($urandom_range(0, 2) != 0);
            flush  = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 1'b0; iv1 = '0; allow1 = 1'b1;
        repeat (3) step();

        // Random traffic on the single-entry instance.
        for (int c = 0; c < 300; c++) begin
            rand_in();
            iv0    = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            allow0 = ($urandom_range(0, 2) != 0);
            flush  = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 1'b0;

        // Single-entry streaming, then combinational back-pressure.
        allow0 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            rand_in();
            iv0 = N'($urandom_range(1, 7));
            step();
        end
        iv0 = '0;
        allow0 = 1'b0;
        #1;
        chk("t6_rdy_comb", OW'(rdy0), OW'(1'b0));
        @(posedge clk); #1;
        allow0 = 1'b1;
        repeat (2) step();

        // Asynchronous reset in the middle of a cycle.
        allow1 = 1'b0;
        rand_in(); iv1 = 3'b111; step();
        rand_in(); iv1 = 3'b011; step();
        iv1 = '0;
        #2;
        resetn = 1'b0;
        #1;
        chk("t1_out1", out1, '0);
        chk("t1_out0", out0, '0);
        chk("t1_rdy1", OW'(rdy1), OW'(1'b1));
        @(posedge clk); #1;
        resetn = 1'b1;

        for (int c = 0; c < 40; c++) begin
            rand_in();
            iv1    = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
            allow1 = ($urandom_range(0, 1) != 0);
            step();
        end
        iv1 = '0; iv0 = '0; allow1 = 1'b1; allow0 = 1'b1; flush = 1'b0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
